// File: rtl/dmem_pkg.sv
// Shared types and default segment bounds for the data memory arbiter.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_LSU = 1'b0,
        OWN_STK = 1'b1
    } owner_e;

    localparam logic [31:0] DEF_DATA_START  = 32'd0;
    localparam logic [31:0] DEF_DATA_END    = 32'd255;
    localparam logic [31:0] DEF_STACK_START = 32'd256;
    localparam logic [31:0] DEF_STACK_END   = 32'd511;

    // Inclusive unsigned range check on a word address.
    function automatic logic in_bounds(input logic [31:0] addr,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester handshakes plus the data memory port, bundled for the arbiter.
interface dmem_arbiter_if;
    logic        lsu_req, lsu_we, lsu_gnt, lsu_done;
    logic [31:0] lsu_addr, lsu_wdata;
    logic        stk_req, stk_we, stk_gnt, stk_done;
    logic [31:0] stk_addr, stk_wdata;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr, mem_rd;

    // Requesters and the memory model sit on this side.
    modport master (
        output lsu_req, lsu_we, lsu_addr, lsu_wdata,
        output stk_req, stk_we, stk_addr, stk_wdata,
        output mem_rdata,
        input  lsu_gnt, lsu_done, stk_gnt, stk_done,
        input  rdata, err, mem_addr, mem_wdata, mem_wr, mem_rd
    );

    // The arbiter itself.
    modport slave (
        input  lsu_req, lsu_we, lsu_addr, lsu_wdata,
        input  stk_req, stk_we, stk_addr, stk_wdata,
        input  mem_rdata,
        output lsu_gnt, lsu_done, stk_gnt, stk_done,
        output rdata, err, mem_addr, mem_wdata, mem_wr, mem_rd
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; pointer remembers the last winner.
module rr_arbiter2
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt
);
    owner_e ptr_q, ptr_d;

    // Grant decode: lone requester wins, on a tie the non-last-winner wins.
    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr_q == OWN_STK) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (upd && gnt[1])
            ptr_d = OWN_STK;
        else if (upd && gnt[0])
            ptr_d = OWN_LSU;
    end

    // Pointer register; reset favours LSU on the first tie.
    always_ff @(posedge clk) begin
        if (reset)
            ptr_q <= OWN_STK;
        else
            ptr_q <= ptr_d;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Sequencer/arbiter for the shared single-port data memory (LSU vs STK).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter logic [31:0] DATA_START  = DEF_DATA_START,
    parameter logic [31:0] DATA_END    = DEF_DATA_END,
    parameter logic [31:0] STACK_START = DEF_STACK_START,
    parameter logic [31:0] STACK_END   = DEF_STACK_END
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic        we_q, we_d;
    logic        legal_q, legal_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  arb_req, arb_gnt;
    logic        in_access, in_resp;

    // Only offer requests to the arbiter when a new access can start.
    assign arb_req = (state_q == ST_IDLE && !reset) ? {bus.stk_req, bus.lsu_req} : 2'b00;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (arb_req),
        .upd   (|arb_gnt),
        .gnt   (arb_gnt)
    );

    // Next-state: latch the winner's command in IDLE, capture read data in ACCESS.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        legal_d = legal_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_gnt[1]) begin
                    owner_d = OWN_STK;
                    we_d    = bus.stk_we;
                    addr_d  = bus.stk_addr;
                    wdata_d = bus.stk_wdata;
                    legal_d = in_bounds(bus.stk_addr, STACK_START, STACK_END);
                    state_d = ST_ACCESS;
                end else if (arb_gnt[0]) begin
                    owner_d = OWN_LSU;
                    we_d    = bus.lsu_we;
                    addr_d  = bus.lsu_addr;
                    wdata_d = bus.lsu_wdata;
                    legal_d = in_bounds(bus.lsu_addr, DATA_START, DATA_END);
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Illegal accesses and writes always report zero read data.
                rdata_d = (legal_q && !we_q) ? bus.mem_rdata : 32'd0;
                state_d = ST_RESP;
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and command registers; reset drops any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_LSU;
            we_q    <= 1'b0;
            legal_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            legal_q <= legal_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decode from state only (except gnt); reset masks everything.
    assign in_access = (state_q == ST_ACCESS) && !reset;
    assign in_resp   = (state_q == ST_RESP) && !reset;

    assign bus.lsu_gnt   = arb_gnt[0];
    assign bus.stk_gnt   = arb_gnt[1];
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wr    = in_access && we_q && legal_q;
    assign bus.mem_rd    = in_access && !we_q && legal_q;
    assign bus.lsu_done  = in_resp && (owner_q == OWN_LSU);
    assign bus.stk_done  = in_resp && (owner_q == OWN_STK);
    assign bus.err       = in_resp && !legal_q;
    assign bus.rdata     = in_resp ? rdata_q : 32'd0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model checked every cycle plus
// directed transactions with hand-computed expectations.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_run = 0;
    int   n_fail = 0;
    int   cyc = 0;

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory attached to the DUT: combinational read, write on rising edge.
    logic [31:0] mem [0:1023];
    assign bus.mem_rdata = mem[bus.mem_addr[9:0]];
    always @(posedge clk) if (bus.mem_wr) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // A transaction lasts three cycles from grant; m_left counts the cycles
    // still to go after the grant cycle (2 = strobe cycle, 1 = done cycle).
    logic [31:0] model_mem [0:1023];
    int          m_left = 0;
    int          m_last = 1;           // 0 = LSU, 1 = STK
    int          t_who;
    logic        t_we, t_legal;
    logic [31:0] t_addr, t_wdata, t_rdata;

    function automatic int pick();
        if (bus.lsu_req && bus.stk_req) return (m_last == 1) ? 0 : 1;
        if (bus.lsu_req) return 0;
        if (bus.stk_req) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0;
            m_last = 1;
        end else if (m_left > 0) begin
            if (m_left == 2) begin
                if (t_legal && t_we) model_mem[t_addr[9:0]] = t_wdata;
                t_rdata = (t_legal && !t_we) ? model_mem[t_addr[9:0]] : 32'd0;
            end
            m_left--;
        end else begin
            automatic int w = pick();
            if (w >= 0) begin
                t_who   = w;
                t_we    = (w == 0) ? bus.lsu_we : bus.stk_we;
                t_addr  = (w == 0) ? bus.lsu_addr : bus.stk_addr;
                t_wdata = (w == 0) ? bus.lsu_wdata : bus.stk_wdata;
                t_legal = (w == 0) ? (t_addr <= 32'd255)
                                   : (t_addr >= 32'd256 && t_addr <= 32'd511);
                m_last  = w;
                m_left  = 2;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        automatic bit   run  = !reset;
        automatic int   w    = (run && m_left == 0) ? pick() : -1;
        automatic logic strb = run && m_left == 2 && t_legal;
        automatic logic resp = run && m_left == 1;
        chk("m_lsu_gnt", 32'(bus.lsu_gnt), 32'(w == 0));
        chk("m_stk_gnt", 32'(bus.stk_gnt), 32'(w == 1));
        chk("m_mem_wr", 32'(bus.mem_wr), 32'(strb && t_we));
        chk("m_mem_rd", 32'(bus.mem_rd), 32'(strb && !t_we));
        if (strb) chk("m_mem_addr", bus.mem_addr, t_addr);
        if (strb && t_we) chk("m_mem_wdata", bus.mem_wdata, t_wdata);
        chk("m_lsu_done", 32'(bus.lsu_done), 32'(resp && t_who == 0));
        chk("m_stk_done", 32'(bus.stk_done), 32'(resp && t_who == 1));
        chk("m_err", 32'(bus.err), 32'(resp && !t_legal));
        chk("m_rdata", bus.rdata, resp ? t_rdata : 32'd0);
    end

    // Grant log for the round-robin test.
    int gl_who[$];
    int gl_cyc[$];
    always @(negedge clk) begin
        if (bus.lsu_gnt) begin gl_who.push_back(0); gl_cyc.push_back(cyc); end
        if (bus.stk_gnt) begin gl_who.push_back(1); gl_cyc.push_back(cyc); end
    end

    // ---------------- directed stimulus ----------------
    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit stk, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        if (stk) begin
            bus.stk_req = 1'b1; bus.stk_we = we; bus.stk_addr = addr; bus.stk_wdata = wdata;
        end else begin
            bus.lsu_req = 1'b1; bus.lsu_we = we; bus.lsu_addr = addr; bus.lsu_wdata = wdata;
        end
    endtask

    // One isolated access with literal expectations for each of its 3 cycles.
    task automatic txn(input bit stk, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit exp_strobe,
                       input bit exp_err, input logic [31:0] exp_rdata);
        drive(stk, we, addr, wdata);
        @(negedge clk);
        chk("t_gnt", 32'(stk ? bus.stk_gnt : bus.lsu_gnt), 32'd1);
        next_cyc();
        bus.lsu_req = 1'b0; bus.stk_req = 1'b0;
        @(negedge clk);
        chk("t_strobe", 32'(we ? bus.mem_wr : bus.mem_rd), 32'(exp_strobe));
        if (exp_strobe) chk("t_addr", bus.mem_addr, addr);
        next_cyc();
        @(negedge clk);
        chk("t_done", 32'(stk ? bus.stk_done : bus.lsu_done), 32'd1);
        chk("t_err", 32'(bus.err), 32'(exp_err));
        chk("t_rdata", bus.rdata, exp_rdata);
        next_cyc();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[5] = 32'hDEADBEEF; mem[10] = 32'h0000_0010; mem[400] = 32'h0000_0400;
        mem[255] = 32'h0002_55AA; mem[256] = 32'h0002_56BB;
        for (int i = 0; i < 1024; i++) model_mem[i] = mem[i];

        reset = 1'b1;
        bus.lsu_req = 1'b0; bus.lsu_we = 1'b0; bus.lsu_addr = '0; bus.lsu_wdata = '0;
        bus.stk_req = 1'b0; bus.stk_we = 1'b0; bus.stk_addr = '0; bus.stk_wdata = '0;
        repeat (2) next_cyc();
        @(negedge clk);
        chk("rst_outputs", {bus.lsu_gnt, bus.stk_gnt, bus.lsu_done, bus.stk_done,
                            bus.err, bus.mem_wr, bus.mem_rd}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        next_cyc();
        reset = 1'b0;
        next_cyc();

        // LSU read of a preloaded word
        txn(1'b0, 1'b0, 32'd5, 32'd0, 1'b1, 1'b0, 32'hDEADBEEF);

        // STK write then read-back
        txn(1'b1, 1'b1, 32'd300, 32'h0000_1234, 1'b1, 1'b0, 32'd0);
        chk("wr_commit", mem[300], 32'h0000_1234);
        txn(1'b1, 1'b0, 32'd300, 32'd0, 1'b1, 1'b0, 32'h0000_1234);

        // Both held: expect LSU, STK, LSU, STK, three cycles apart
        gl_who.delete(); gl_cyc.delete();
        drive(1'b0, 1'b0, 32'd10, 32'd0);
        drive(1'b1, 1'b0, 32'd400, 32'd0);
        repeat (10) next_cyc();
        bus.lsu_req = 1'b0; bus.stk_req = 1'b0;
        repeat (3) next_cyc();
        chk("rr_count", 32'(gl_who.size()), 32'd4);
        if (gl_who.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("rr_order", 32'(gl_who[i]), 32'(i % 2));
            for (int i = 1; i < 4; i++) chk("rr_spacing", 32'(gl_cyc[i] - gl_cyc[i-1]), 32'd3);
        end

        // LSU write outside the data segment
        txn(1'b0, 1'b1, 32'd300, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'd0);
        chk("illegal_untouched", mem[300], 32'h0000_1234);

        // Reset during the strobe cycle of an STK write
        drive(1'b1, 1'b1, 32'd310, 32'hAAAA_5555);
        @(negedge clk);
        chk("rw_gnt", 32'(bus.stk_gnt), 32'd1);
        next_cyc();
        bus.stk_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rw_no_wr", 32'(bus.mem_wr), 32'd0);
        next_cyc();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rw_no_done", 32'(bus.stk_done), 32'd0);
            next_cyc();
        end
        chk("rw_untouched", mem[310], 32'd0);
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 32'd256, 32'd0);
        @(negedge clk);
        chk("rw_tie_lsu", {bus.stk_gnt, bus.lsu_gnt}, 32'b01);
        next_cyc();
        bus.lsu_req = 1'b0;
        repeat (2) next_cyc();
        @(negedge clk);
        chk("rw_tie_stk", {bus.stk_gnt, bus.lsu_gnt}, 32'b10);
        next_cyc();
        bus.stk_req = 1'b0;
        repeat (3) next_cyc();

        // Segment boundaries
        txn(1'b0, 1'b0, 32'd255, 32'd0, 1'b1, 1'b0, 32'h0002_55AA);
        txn(1'b1, 1'b0, 32'd256, 32'd0, 1'b1, 1'b0, 32'h0002_56BB);
        txn(1'b0, 1'b0, 32'd256, 32'd0, 1'b0, 1'b1, 32'd0);
        txn(1'b1, 1'b0, 32'd255, 32'd0, 1'b0, 1'b1, 32'd0);

        repeat (2) next_cyc();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
